// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Two-stage valid/ready pipeline that extracts and sign-extends
//               RISC-V immediates (I/S/B/J/U). Optional CSR zimm decode for
//               immsrc 101 is enabled by defining IMM_GEN_ZIMM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [24:0]      i_instr,
  input  logic [2:0]       i_immsrc,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);

  localparam logic [2:0] C_SRC_I    = 3'b000;
  localparam logic [2:0] C_SRC_S    = 3'b001;
  localparam logic [2:0] C_SRC_B    = 3'b010;
  localparam logic [2:0] C_SRC_J    = 3'b011;
  localparam logic [2:0] C_SRC_U    = 3'b100;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] C_SRC_ZIMM = 3'b101;
`endif

  // Stage A: raw instruction fields
  logic             valid_a_q, valid_a_d;
  logic [24:0]      instr_a_q, instr_a_d;
  logic [2:0]       src_a_q,   src_a_d;
  logic [TAG_W-1:0] tag_a_q,   tag_a_d;

  // Stage B: decoded result
  logic             valid_b_q, valid_b_d;
  logic [XLEN-1:0]  imm_b_q,   imm_b_d;
  logic [TAG_W-1:0] tag_b_q,   tag_b_d;
  logic             ill_b_q,   ill_b_d;

  logic             w_adv_b;
  logic             w_accept;
  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_ill;

  assign w_adv_b  = !valid_b_q || i_ready;
  assign o_ready  = !valid_a_q || w_adv_b;
  assign w_accept = i_valid && o_ready;

  // instr_a_q holds instruction bits [31:7], so instruction bit k is index k-7.
  always_comb begin
    w_dec_imm = '0;
    w_dec_ill = 1'b0;
    case (src_a_q)
      C_SRC_I: w_dec_imm = XLEN'($signed(instr_a_q[24:13]));
      C_SRC_S: w_dec_imm = XLEN'($signed({instr_a_q[24:18], instr_a_q[4:0]}));
      C_SRC_B: w_dec_imm = XLEN'($signed({instr_a_q[24], instr_a_q[0],
                                          instr_a_q[23:18], instr_a_q[4:1], 1'b0}));
      C_SRC_J: w_dec_imm = XLEN'($signed({instr_a_q[24], instr_a_q[12:5],
                                          instr_a_q[13], instr_a_q[23:14], 1'b0}));
      C_SRC_U: w_dec_imm = XLEN'($signed({instr_a_q[24:5], 12'b0}));
`ifdef IMM_GEN_ZIMM_EN
      C_SRC_ZIMM: w_dec_imm = XLEN'(instr_a_q[12:8]);
`endif
      default: w_dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    valid_a_d = valid_a_q;
    instr_a_d = instr_a_q;
    src_a_d   = src_a_q;
    tag_a_d   = tag_a_q;
    if (i_flush) begin
      valid_a_d = 1'b0;
    end else if (o_ready) begin
      valid_a_d = i_valid;
      if (w_accept) begin
        instr_a_d = i_instr;
        src_a_d   = i_immsrc;
        tag_a_d   = i_tag;
      end
    end
  end

  always_comb begin
    valid_b_d = valid_b_q;
    imm_b_d   = imm_b_q;
    tag_b_d   = tag_b_q;
    ill_b_d   = ill_b_q;
    if (i_flush) begin
      valid_b_d = 1'b0;
    end else if (w_adv_b) begin
      valid_b_d = valid_a_q;
      if (valid_a_q) begin
        imm_b_d = w_dec_imm;
        tag_b_d = tag_a_q;
        ill_b_d = w_dec_ill;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_a_q <= 1'b0;
      instr_a_q <= '0;
      src_a_q   <= '0;
      tag_a_q   <= '0;
      valid_b_q <= 1'b0;
      imm_b_q   <= '0;
      tag_b_q   <= '0;
      ill_b_q   <= 1'b0;
    end else begin
      valid_a_q <= valid_a_d;
      instr_a_q <= instr_a_d;
      src_a_q   <= src_a_d;
      tag_a_q   <= tag_a_d;
      valid_b_q <= valid_b_d;
      imm_b_q   <= imm_b_d;
      tag_b_q   <= tag_b_d;
      ill_b_q   <= ill_b_d;
    end
  end

  assign o_valid   = valid_b_q;
  assign o_imm     = imm_b_q;
  assign o_tag     = tag_b_q;
  assign o_illegal = ill_b_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench for imm_gen_pipe (XLEN=32 and XLEN=64 copies
//               driven in lockstep), arithmetic reference model of immediates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic [24:0]      i_instr = '0;
  logic [2:0]       i_immsrc = '0;
  logic [TAG_W-1:0] i_tag = '0;

  logic             o_ready, o_valid, o_illegal;
  logic [31:0]      o_imm;
  logic [TAG_W-1:0] o_tag;
  logic             o_ready64, o_valid64, o_illegal64;
  logic [63:0]      o_imm64;
  logic [TAG_W-1:0] o_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_instr(i_instr), .i_immsrc(i_immsrc), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_imm(o_imm), .o_tag(o_tag),
    .o_illegal(o_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready64), .i_instr(i_instr), .i_immsrc(i_immsrc), .i_tag(i_tag),
    .o_valid(o_valid64), .i_ready(i_ready), .o_imm(o_imm64), .o_tag(o_tag64),
    .o_illegal(o_illegal64)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [63:0]      imm;
    logic             ill;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  logic [63:0] cur_exp = '0;
  logic        cur_ill = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Immediate value as a signed integer from the instruction's field layout.
  function automatic void ref_model(input logic [31:0] ins, input logic [2:0] src,
                                    output logic [63:0] imm, output logic ill);
    longint f;
    int     n;
    bit     sext;
    f = 0; n = 32; sext = 1'b1; ill = 1'b0; imm = '0;
    case (src)
      3'd0: begin f = longint'(ins[31:20]); n = 12; end
      3'd1: begin f = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); n = 12; end
      3'd2: begin
        f = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        n = 13;
      end
      3'd3: begin
        f = longint'(ins[31]) * (longint'(1) << 20) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        n = 21;
      end
      3'd4: begin f = longint'(ins[31:12]) * 4096; n = 32; end
`ifdef IMM_GEN_ZIMM_EN
      3'd5: begin f = longint'(ins[19:15]); sext = 1'b0; end
`endif
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      if (sext && f >= (longint'(1) << (n - 1))) f = f - (longint'(1) << n);
      imm = f;
    end
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic [2:0] src,
                        input logic [TAG_W-1:0] tag);
    logic [63:0] e;
    logic        il;
    i_instr  = ins[31:7];
    i_immsrc = src;
    i_tag    = tag;
    ref_model(ins, src, e, il);
    cur_exp = e;
    cur_ill = il;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an entry and hold it until accepted; returns just after the accepting edge.
  task automatic offer(input logic [31:0] ins, input logic [2:0] src,
                       input logic [TAG_W-1:0] tag, input logic [63:0] exp_imm,
                       input logic exp_ill, input bit use_const);
    set_in(ins, src, tag);
    if (use_const) begin
      cur_exp = exp_imm;
      cur_ill = exp_ill;
    end
    i_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_ready) begin
        tick();
        return;
      end
    end
    total++; bad++;
    $display("FAIL accept_timeout: tag=%0d never accepted (got o_ready=%0b, need 1)", tag, o_ready);
    tick();
  endtask

  task automatic drain();
    i_valid = 1'b0;
    for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries outstanding, need 0", sb.size());
    end
  endtask

  // Monitor / scoreboard
  logic [31:0]      p_imm;
  logic [TAG_W-1:0] p_tag;
  logic             p_ill;
  bit               prev_stall = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!(o_valid && o_imm == p_imm && o_tag == p_tag && o_illegal == p_ill)) begin
          bad++;
          $display("FAIL hold: got v=%0b imm=%h tag=%0d ill=%0b, need v=1 imm=%h tag=%0d ill=%0b",
                   o_valid, o_imm, o_tag, o_illegal, p_imm, p_tag, p_ill);
        end
      end
      if (o_valid && i_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got tag=%0d imm=%h, need no output", o_tag, o_imm);
        end else begin
          exp_t e;
          int   lat;
          e = sb.pop_front();
          if (o_imm !== e.imm[31:0] || o_imm64 !== e.imm || !o_valid64) begin
            bad++;
            $display("FAIL imm: tag=%0d got %h/%h v64=%0b, need %h/%h",
                     e.tag, o_imm, o_imm64, o_valid64, e.imm[31:0], e.imm);
          end
          total++;
          if (o_tag !== e.tag || o_tag64 !== e.tag) begin
            bad++;
            $display("FAIL tag: got %0d/%0d, need %0d", o_tag, o_tag64, e.tag);
          end
          total++;
          if (o_illegal !== e.ill || o_illegal64 !== e.ill) begin
            bad++;
            $display("FAIL illegal: tag=%0d got %0b/%0b, need %0b", e.tag, o_illegal, o_illegal64, e.ill);
          end
          total++;
          lat = cyc - e.cyc;
          if (chk_lat ? (lat != 2) : (lat < 2)) begin
            bad++;
            $display("FAIL latency: tag=%0d got %0d cycles, need %s2", e.tag, lat, chk_lat ? "" : ">=");
          end
        end
      end
      if (i_flush) sb.delete();
      else if (i_valid && o_ready)
        sb.push_back('{imm: cur_exp, ill: cur_ill, tag: i_tag, cyc: cyc});
      prev_stall = o_valid && !i_ready && !i_flush;
      p_imm = o_imm; p_tag = o_tag; p_ill = o_illegal;
    end
  end

  task automatic check_reset_outputs(input string name);
    total++;
    if (o_valid || o_imm != 0 || o_tag != 0 || o_illegal || !o_ready ||
        o_valid64 || o_imm64 != 0 || o_tag64 != 0 || o_illegal64 || !o_ready64) begin
      bad++;
      $display("FAIL %s: got v=%0b imm=%h tag=%0d ill=%0b rdy=%0b imm64=%h, need v=0 imm=0 tag=0 ill=0 rdy=1",
               name, o_valid, o_imm, o_tag, o_illegal, o_ready, o_imm64);
    end
  endtask

  initial begin
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Directed per-format decode, unstalled
    chk_lat = 1'b1;
    i_ready = 1'b1;
    offer(32'h8000_0000, 3'b000, 5'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b1);
    offer(32'h0200_0100, 3'b001, 5'd2, 64'h0000_0000_0000_0022, 1'b0, 1'b1);
    offer(32'h0000_0080, 3'b010, 5'd3, 64'h0000_0000_0000_0800, 1'b0, 1'b1);
    offer(32'h8000_0000, 3'b011, 5'd4, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 1'b1);
    offer(32'h1234_5000, 3'b100, 5'd5, 64'h0000_0000_1234_5000, 1'b0, 1'b1);
    offer(32'h8000_0000, 3'b100, 5'd6, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
    offer(32'h000F_8000, 3'b101, 5'd7, 64'h0000_0000_0000_001F, 1'b0, 1'b1);
`else
    offer(32'h000F_8000, 3'b101, 5'd7, 64'h0, 1'b1, 1'b1);
`endif
    offer(32'hFFFF_FF80, 3'b111, 5'd8, 64'h0, 1'b1, 1'b1);
    offer(32'hFFFF_FF80, 3'b110, 5'd9, 64'h0, 1'b1, 1'b1);
    drain();

    // Backpressure: two accepts fill the pipe, third waits
    chk_lat = 1'b0;
    i_ready = 1'b0;
    offer(32'h1234_5000, 3'b000, 5'd1, 64'h0, 1'b0, 1'b0);
    offer(32'h0000_0080, 3'b010, 5'd2, 64'h0, 1'b0, 1'b0);
    set_in(32'h8000_0000, 3'b011, 5'd3);
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (o_ready || !o_valid || o_tag != 5'd1) begin
        bad++;
        $display("FAIL backpressure: got rdy=%0b v=%0b tag=%0d, need rdy=0 v=1 tag=1", o_ready, o_valid, o_tag);
      end
    end
    tick();
    i_ready = 1'b1;
    offer(32'h8000_0000, 3'b011, 5'd3, 64'h0, 1'b0, 1'b0);
    drain();

    // Flush with two entries in flight and a third offered
    i_ready = 1'b0;
    offer(32'h0000_0080, 3'b000, 5'd4, 64'h0, 1'b0, 1'b0);
    offer(32'h0000_0100, 3'b001, 5'd5, 64'h0, 1'b0, 1'b0);
    set_in(32'h1000_0000, 3'b100, 5'd6);
    i_valid = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    total++;
    if (o_valid || o_valid64) begin
      bad++;
      $display("FAIL flush: got o_valid=%0b, need 0", o_valid);
    end
    i_ready = 1'b1;
    repeat (5) tick();
    drain();

    // Mid-stream asynchronous reset
    i_ready = 1'b0;
    offer(32'h8765_4000, 3'b100, 5'd10, 64'h0, 1'b0, 1'b0);
    offer(32'h0000_0080, 3'b010, 5'd11, 64'h0, 1'b0, 1'b0);
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    tick();
    rst = 1'b0;
    i_ready = 1'b1;
    chk_lat = 1'b1;
    offer(32'hFFF0_0000, 3'b000, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    drain();

    // Random stream, always-ready: full throughput with exact latency
    for (int k = 0; k < 150; k++) begin
      i_valid = ($urandom % 4) != 0;
      set_in($urandom, 3'($urandom), TAG_W'($urandom));
      tick();
    end
    drain();

    // Random stream with backpressure and occasional flush
    chk_lat = 1'b0;
    for (int k = 0; k < 400; k++) begin
      i_valid = ($urandom % 3) != 0;
      i_ready = ($urandom % 4) != 0;
      i_flush = ($urandom % 40) == 0;
      set_in($urandom, 3'($urandom), TAG_W'($urandom));
      tick();
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
